// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// per-scan result codes and the column drive patterns.
package keypad_pkg;

   localparam int KEY_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } state_t;

   typedef enum logic [1:0] {
      RES_NONE,
      RES_SINGLE,
      RES_MULTI
   } scan_res_t;

   localparam logic [3:0] COL_PAT0 = 4'b1110;
   localparam logic [3:0] COL_PAT1 = 4'b1101;
   localparam logic [3:0] COL_PAT2 = 4'b1011;
   localparam logic [3:0] COL_PAT3 = 4'b0111;

   function automatic logic [3:0] col_pattern(input logic [1:0] idx);
      case (idx)
         2'd0:    return COL_PAT0;
         2'd1:    return COL_PAT1;
         2'd2:    return COL_PAT2;
         default: return COL_PAT3;
      endcase
   endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column scanner: slot divider, active-low column drive, row synchronizer and
// per-scan accumulation of low intersections into NONE / SINGLE / MULTI.
module keypad_col_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       scan_done,
   output logic [1:0] scan_res,
   output logic [3:0] scan_key
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       col_idx;
   logic [3:0]       row_meta;
   logic [3:0]       row_sync;
   logic [1:0]       acc_hits;
   logic [3:0]       acc_key;
   logic             slot_last;
   logic [3:0]       row_low;
   logic [1:0]       slot_hits;
   logic [1:0]       slot_row;
   logic [2:0]       hit_sum;
   logic [1:0]       tot_hits;
   logic [3:0]       next_key;

   assign slot_last = (div_cnt == DIV_LAST);
   assign row_low   = ~row_sync;

   // Hit counts saturate at 2: beyond that only "more than one" matters.
   always_comb begin
      slot_hits = 2'd0;
      slot_row  = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (row_low[r]) begin
            slot_row = 2'(r);
            if (slot_hits != 2'd2) slot_hits = slot_hits + 2'd1;
         end
      end
      hit_sum  = 3'(acc_hits) + 3'(slot_hits);
      tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      next_key = (acc_hits != 2'd0) ? acc_key : {col_idx, slot_row};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt   <= '0;
         col_idx   <= 2'd0;
         col       <= COL_PAT0;
         row_meta  <= 4'hF;
         row_sync  <= 4'hF;
         acc_hits  <= 2'd0;
         acc_key   <= 4'd0;
         scan_done <= 1'b0;
         scan_res  <= RES_NONE;
         scan_key  <= 4'd0;
      end else begin
         row_meta  <= row;
         row_sync  <= row_meta;
         scan_done <= 1'b0;
         if (slot_last) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
            col     <= col_pattern(col_idx + 2'd1);
            if (col_idx == 2'd3) begin
               scan_done <= 1'b1;
               scan_key  <= next_key;
               acc_hits  <= 2'd0;
               acc_key   <= 4'd0;
               if (tot_hits == 2'd0)      scan_res <= RES_NONE;
               else if (tot_hits == 2'd1) scan_res <= RES_SINGLE;
               else                       scan_res <= RES_MULTI;
            end else begin
               acc_hits <= tot_hits;
               acc_key  <= next_key;
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner top: debounce FSM and key outputs.
// Auto-repeat of a held key is compiled in when KEYPAD_REPEAT_EN is defined.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 8,
   parameter int REPEAT_SCANS   = 125
) (
   input  logic             clk100mhz,
   input  logic             reset,
   input  logic [3:0]       row,
   output logic [3:0]       col,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_held
);

   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic [KEY_W-1:0] cand;
   logic [KEY_W-1:0] cand_nxt;
   logic [KEY_W-1:0] code_nxt;
   logic             valid_nxt;
   logic             held_nxt;
   logic             scan_done;
   logic [1:0]       scan_res;
   logic [3:0]       scan_key;
   logic             res_none;
   logic             res_cand;

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_SCANS + 1);
   localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_SCANS);
   logic [REP_W-1:0] rep_cnt;
   logic [REP_W-1:0] rep_nxt;
`endif

   keypad_col_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_col_scan (
      .clk       (clk100mhz),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .scan_done (scan_done),
      .scan_res  (scan_res),
      .scan_key  (scan_key)
   );

   assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   assign res_none = (scan_res == RES_NONE);
   assign res_cand = (scan_res == RES_SINGLE) && (scan_key == cand);

   always_ff @(posedge clk100mhz) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         cand      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt   <= '0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         cand      <= cand_nxt;
         key_code  <= code_nxt;
         key_valid <= valid_nxt;
         key_held  <= held_nxt;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt   <= rep_nxt;
`endif
      end
   end

   // Transitions only happen on scan_done; MULTI never starts or extends a debounce.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cand_nxt  = cand;
      code_nxt  = key_code;
      valid_nxt = 1'b0;
      held_nxt  = key_held;
`ifdef KEYPAD_REPEAT_EN
      rep_nxt   = rep_cnt;
`endif
      if (scan_done) begin
         case (state)
            ST_IDLE: begin
               if (scan_res == RES_SINGLE) begin
                  cand_nxt = scan_key;
                  if (CNT_MAX <= CNT_W'(1)) begin
                     state_nxt = ST_PRESSED;
                     cnt_nxt   = '0;
                     code_nxt  = scan_key;
                     valid_nxt = 1'b1;
                     held_nxt  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                     rep_nxt   = '0;
`endif
                  end else begin
                     state_nxt = ST_DEBOUNCE;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (res_cand) begin
                  if (cnt_inc >= CNT_MAX) begin
                     state_nxt = ST_PRESSED;
                     cnt_nxt   = '0;
                     code_nxt  = cand;
                     valid_nxt = 1'b1;
                     held_nxt  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                     rep_nxt   = '0;
`endif
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end else begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end
            end
            ST_PRESSED: begin
               if (res_none) begin
                  state_nxt = ST_RELEASE;
                  cnt_nxt   = CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
                  rep_nxt   = '0;
`endif
               end
`ifdef KEYPAD_REPEAT_EN
               else if (res_cand) begin
                  if (rep_cnt >= REP_MAX - REP_W'(1)) begin
                     valid_nxt = 1'b1;
                     rep_nxt   = '0;
                  end else begin
                     rep_nxt = rep_cnt + REP_W'(1);
                  end
               end
`endif
            end
            ST_RELEASE: begin
               if (res_none) begin
                  if (cnt_inc >= CNT_MAX) begin
                     state_nxt = ST_IDLE;
                     cnt_nxt   = '0;
                     held_nxt  = 1'b0;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end else begin
                  state_nxt = ST_PRESSED;
                  cnt_nxt   = '0;
`ifdef KEYPAD_REPEAT_EN
                  rep_nxt   = '0;
`endif
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural key matrix driving the rows;
// expected pulse counts, codes and cycle stamps are hand-derived per scenario.
module tb_keypad_scan;

   logic        clk100mhz;
   logic        reset;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;

   logic [15:0] keys;
   int          vec_cnt = 0;
   int          err_cnt = 0;
   int          cyc = 0;
   int          pulse_cnt = 0;
   logic [3:0]  last_code = 4'd0;
   int          last_pulse_cyc = 0;
   int          rise_cyc = 0;
   int          fall_cyc = 0;
   logic        held_d = 1'b0;
   logic        valid_d = 1'b0;
   int          t0;
   int          p0;
   logic [3:0]  exp_col [4];

   keypad_scan #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3),
      .REPEAT_SCANS   (5)
   ) dut (
      .clk100mhz (clk100mhz),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial begin
      clk100mhz = 1'b0;
      forever #5 clk100mhz = ~clk100mhz;
   end

   always @(posedge clk100mhz) cyc <= cyc + 1;

   // Key index is {col, row}; a pressed key pulls its row low while its column is driven.
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (!col[c] && keys[c*4 + r]) row[r] = 1'b0;
   end

   always @(negedge clk100mhz) begin
      if (key_valid) begin
         checkOutput("valid_width", 32'(valid_d), 32'd0);
         pulse_cnt      = pulse_cnt + 1;
         last_code      = key_code;
         last_pulse_cyc = cyc;
      end
      if (key_held && !held_d) rise_cyc = cyc;
      if (!key_held && held_d) fall_cyc = cyc;
      held_d  = key_held;
      valid_d = key_valid;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vec_cnt = vec_cnt + 1;
      if (actual !== expected) begin
         err_cnt = err_cnt + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] k);
      keys = k;
   endtask

   task automatic waitScans(input int n);
      repeat (16 * n) @(posedge clk100mhz);
      #1;
   endtask

   // Returns just after the edge that starts a new scan (col wraps 0111 -> 1110).
   task automatic alignScan();
      logic [3:0] prev_col;
      bit         found;
      found    = 1'b0;
      prev_col = col;
      for (int i = 0; i < 64 && !found; i++) begin
         @(posedge clk100mhz);
         #1;
         if (prev_col == 4'b0111 && col == 4'b1110) found = 1'b1;
         prev_col = col;
      end
      checkOutput("align", 32'(found), 32'd1);
   endtask

   initial begin
      exp_col[0] = 4'b1101;
      exp_col[1] = 4'b1011;
      exp_col[2] = 4'b0111;
      exp_col[3] = 4'b1110;
      reset = 1'b1;
      applyStimulus(16'h0000);
      repeat (3) @(posedge clk100mhz);
      #1;
      checkOutput("rst_col", 32'(col), 32'hE);
      checkOutput("rst_code", 32'(key_code), 32'd0);
      checkOutput("rst_valid", 32'(key_valid), 32'd0);
      checkOutput("rst_held", 32'(key_held), 32'd0);
      reset = 1'b0;

      repeat (6) @(posedge clk100mhz);
      #1;
      checkOutput("pre_midrst_col", 32'(col), 32'hD);
      reset = 1'b1;
      @(posedge clk100mhz);
      #1;
      checkOutput("midrst_col", 32'(col), 32'hE);
      checkOutput("midrst_valid", 32'(key_valid), 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         repeat (4) @(posedge clk100mhz);
         #1;
         checkOutput("col_seq", 32'(col), 32'(exp_col[k]));
      end

      $display("[TB] clean press of key 1001");
      alignScan();
      t0 = cyc;
      p0 = pulse_cnt;
      applyStimulus(16'h0200);
      waitScans(2);
      checkOutput("clean_early", pulse_cnt, p0);
      waitScans(4);
      applyStimulus(16'h0000);
      waitScans(4);
      checkOutput("clean_count", pulse_cnt, p0 + 1);
      checkOutput("clean_code", 32'(last_code), 32'd9);
      checkOutput("clean_pulse_cyc", last_pulse_cyc, t0 + 49);
      checkOutput("clean_rise_cyc", rise_cyc, t0 + 49);
      checkOutput("clean_fall_cyc", fall_cyc, t0 + 145);
      checkOutput("clean_held_end", 32'(key_held), 32'd0);
      checkOutput("clean_code_kept", 32'(key_code), 32'd9);

      $display("[TB] bounce on key 0101");
      alignScan();
      t0 = cyc;
      p0 = pulse_cnt;
      applyStimulus(16'h0020);
      waitScans(2);
      applyStimulus(16'h0000);
      waitScans(1);
      applyStimulus(16'h0020);
      waitScans(3);
      applyStimulus(16'h0000);
      waitScans(4);
      checkOutput("bounce_count", pulse_cnt, p0 + 1);
      checkOutput("bounce_code", 32'(last_code), 32'd5);
      checkOutput("bounce_pulse_cyc", last_pulse_cyc, t0 + 97);

      $display("[TB] ghost rejection with keys 0000 and 0101");
      alignScan();
      t0 = cyc;
      p0 = pulse_cnt;
      applyStimulus(16'h0021);
      waitScans(6);
      checkOutput("ghost_none", pulse_cnt, p0);
      applyStimulus(16'h0001);
      waitScans(3);
      applyStimulus(16'h0000);
      waitScans(4);
      checkOutput("ghost_count", pulse_cnt, p0 + 1);
      checkOutput("ghost_code", 32'(last_code), 32'd0);
      checkOutput("ghost_pulse_cyc", last_pulse_cyc, t0 + 145);

      $display("[TB] rollover: 1111 held, 0011 added");
      alignScan();
      t0 = cyc;
      p0 = pulse_cnt;
      applyStimulus(16'h8000);
      waitScans(3);
      applyStimulus(16'h8008);
      waitScans(4);
      applyStimulus(16'h0000);
      waitScans(2);
      checkOutput("roll_held_mid", 32'(key_held), 32'd1);
      waitScans(2);
      checkOutput("roll_count", pulse_cnt, p0 + 1);
      checkOutput("roll_code", 32'(key_code), 32'd15);
      checkOutput("roll_pulse_cyc", last_pulse_cyc, t0 + 49);
      checkOutput("roll_fall_cyc", fall_cyc, t0 + 161);

      $display("[TB] reset while key 1100 is held");
      alignScan();
      t0 = cyc;
      p0 = pulse_cnt;
      applyStimulus(16'h1000);
      waitScans(4);
      checkOutput("rstp_first_count", pulse_cnt, p0 + 1);
      reset = 1'b1;
      @(posedge clk100mhz);
      #1;
      reset = 1'b0;
      t0 = cyc;
      checkOutput("rstp_held", 32'(key_held), 32'd0);
      checkOutput("rstp_code", 32'(key_code), 32'd0);
      checkOutput("rstp_col", 32'(col), 32'hE);
      waitScans(3);
      checkOutput("rstp_no_early", pulse_cnt, p0 + 1);
      waitScans(1);
      checkOutput("rstp_count", pulse_cnt, p0 + 2);
      checkOutput("rstp_code2", 32'(last_code), 32'd12);
      checkOutput("rstp_pulse_cyc", last_pulse_cyc, t0 + 49);
      applyStimulus(16'h0000);
      waitScans(4);

      $display("[TB] long hold of key 0110");
      alignScan();
      t0 = cyc;
      p0 = pulse_cnt;
      applyStimulus(16'h0040);
      waitScans(18);
      applyStimulus(16'h0000);
      waitScans(4);
`ifdef KEYPAD_REPEAT_EN
      checkOutput("rep_count", pulse_cnt, p0 + 4);
      checkOutput("rep_last_cyc", last_pulse_cyc, t0 + 289);
`else
      checkOutput("rep_count", pulse_cnt, p0 + 1);
      checkOutput("rep_last_cyc", last_pulse_cyc, t0 + 49);
`endif
      checkOutput("rep_code", 32'(last_code), 32'd6);
      checkOutput("rep_fall_cyc", fall_cyc, t0 + 337);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanner for a 4x4 matrix keypad: drives the column lines, samples the row lines, debounces, and emits one 4-bit key code per press. It sits on the input side of the scale front panel. Its `key_code`/`key_valid` pair feeds the weight/price entry logic alongside the existing debounced buttons. It mirrors the multiplexed seven-segment scan on the output side.

## Interface
- `SCAN_DIV`, 100000: clock cycles per column slot (1 ms at 100 MHz).
- `DEBOUNCE_SCANS`, 8: consecutive identical full scans required to accept a press or a release.
- `REPEAT_SCANS`, 125: full scans between auto-repeat pulses. Used only when `KEYPAD_REPEAT_EN` is defined.
- `clk100mhz` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `row` in 4: keypad rows, active-low (pulled up on board), asynchronous.
- `col` out 4: column drive, active-low, exactly one bit low at all times.
- `key_code` out 4: code of the last accepted key, `{col_idx[1:0], row_idx[1:0]}`.
- `key_valid` out 1: one-cycle pulse when a new key is accepted.
- `key_held` out 1: high while the accepted key is considered pressed.

## Operation
- **Column scan**
  - `col` steps through 1110, 1101, 1011, 0111, then wraps. Each pattern is held for `SCAN_DIV` cycles.
  - `row` passes through a 2-FF synchronizer. It is sampled on the last cycle of each slot.
  - Four slots make one full scan. Completion raises an internal one-cycle `scan_done` strobe.
- **Scan result** after each full scan:
  - NONE: no row bit was low in any slot.
  - SINGLE(k): exactly one (col, row) intersection was low.
  - MULTI: two or more intersections were low. MULTI is treated as NONE for press detection, which gives ghost/rollover rejection.
- **FSM states** (all transitions evaluated only on `scan_done`):
  - IDLE: SINGLE(k) -> DEBOUNCE, with cand=k and cnt=1.
  - DEBOUNCE:
    - SINGLE(cand): cnt++.
    - When cnt reaches `DEBOUNCE_SCANS`: -> PRESSED, `key_code`<=cand, `key_valid` pulses, `key_held`<=1.
    - Any other result: -> IDLE, cnt=0.
  - PRESSED:
    - NONE: -> RELEASE, cnt=1.
    - SINGLE(cand): stay.
    - SINGLE(other) or MULTI: stay. No event is produced and `key_code` is unchanged.
  - RELEASE:
    - NONE: cnt++. When cnt reaches `DEBOUNCE_SCANS`: -> IDLE, `key_held`<=0.
    - Any non-NONE result: -> PRESSED, cnt=0. No new `key_valid`.
- **`key_code` persistence**: `key_code` holds its value after release until the next accepted key.
- **Counter widths**: `$clog2(param+1)`. cnt saturates and never wraps.

## Timing
- **Reset values**: `col`=1110, `key_code`=0000, `key_valid`=0, `key_held`=0. State is IDLE; all counters and cand are 0.
- **Reset mid-scan or mid-press**:
  - Everything returns to reset values on the next edge.
  - No `key_valid` is emitted for a key still pressed at reset until it completes a fresh debounce.
- **Press latency**:
  - A key stable from a slot boundary is accepted on the `scan_done` of its `DEBOUNCE_SCANS`-th consecutive scan.
  - Worst case is (`DEBOUNCE_SCANS`+1)×4×`SCAN_DIV` + 3 cycles.
- **`key_valid`**: asserted for exactly one cycle. It coincides with the `key_code` update and is never high twice without an intervening IDLE, except for auto-repeat.
- **`key_held` timing**: rises in the same cycle as `key_valid`. It falls on the `scan_done` that completes the release debounce.
- **Column switching**: `col` changes on the cycle after the slot's sample cycle. Rows therefore always get at least `SCAN_DIV`-1 cycles to settle.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In PRESSED, a repeat counter increments on each `scan_done` with SINGLE(cand).
  - When it reaches `REPEAT_SCANS`, `key_valid` pulses again with the same `key_code` and the counter clears.
  - The counter clears on entry to PRESSED and on entry to RELEASE.
- `KEYPAD_REPEAT_EN` undefined: no repeat logic is compiled. A held key produces exactly one `key_valid`.

## Structure
- Package `keypad_pkg`:
  - State enum (IDLE, DEBOUNCE, PRESSED, RELEASE).
  - Scan result encoding (NONE, SINGLE, MULTI).
  - `KEY_W`=4.
  - Column pattern constants.
- Sub-module `keypad_col_scan`: slot divider, column index, `col` drive, row synchronizer, per-scan result accumulation, and the `scan_done` strobe.
- Top `keypad_scan`: FSM, debounce/repeat counters, and the output registers.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3, `REPEAT_SCANS`=5.
- **Reset**: assert `reset` mid-slot -> next edge gives `col`=1110, `key_code`=0, `key_valid`=0, `key_held`=0. `col` then cycles 1110, 1101, 1011, 0111, 1110 every 4 cycles.
- **Clean press**: model press of col 2/row 1 for 6 scans, then release -> one `key_valid` pulse with `key_code`=1001 on the 3rd `scan_done`. `key_held` falls 3 scans after release.
- **Bounce**: key 0101 pressed 2 scans, released 1 scan, pressed 3 scans -> no pulse during the first attempt, then a single `key_valid` with 0101.
- **Ghost rejection**: keys 0000 and 0101 both low from idle for 6 scans -> no `key_valid`. Then hold 0000 alone for 3 scans -> pulse with 0000.
- **Rollover while held**: hold 1111 until accepted, add 0011 for 4 scans, then drop both -> exactly one `key_valid` (1111) with `key_code` unchanged. `key_held` stays high until release is debounced.
- **Auto-repeat**: with `KEYPAD_REPEAT_EN`, hold 0110 for 15 scans after acceptance -> 3 extra pulses, 5 scans apart. Without the macro -> 1 pulse total.
